tick_bcd_counter: RTL



---
 rtl/tick_bcd_counter_pkg.sv | 13 +
 rtl/tick_bcd_counter_if.sv | 25 ++
 rtl/tick_bcd_counter_bcd_digit.sv | 38 +++
 rtl/tick_bcd_counter.sv | 106 ++++++++++
 4 files changed

// File: rtl/tick_bcd_counter_pkg.sv
// Shared types and constants for the tick-driven two-digit BCD counter.
package tick_cnt_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_bcd_counter_if.sv
// Control/status bundle between the counter and its controller.
interface tick_bcd_counter_if;

  logic       tick_src;
  logic       run;
  logic       up;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] bcd_out;
  logic       tc;
  logic       load_err;
  logic [1:0] state_o;

  modport master (
    output tick_src, run, up, clr, load, load_val,
    input  bcd_out, tc, load_err, state_o
  );

  modport slave (
    input  tick_src, run, up, clr, load, load_val,
    output bcd_out, tc, load_err, state_o
  );

endinterface

// File: rtl/tick_bcd_counter_bcd_digit.sv
// One loadable BCD digit counting up/down between 0 and a supplied limit.
module bcd_digit
  import tick_cnt_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] max,
  input  logic [BCD_W-1:0] load_val,
  output logic             co,
  output logic [BCD_W-1:0] digit
);

  // Carry/borrow is qualified by en so the next digit can use it as its enable.
  always_comb begin
    co = en && (up ? (digit == max) : (digit == '0));
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (en) begin
      if (up) begin
        digit <= (digit == max) ? '0 : digit + 1'b1;
      end else begin
        digit <= (digit == '0) ? max : digit - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_bcd_counter.sv
// Counts rising edges of the divided clock on a 2-digit BCD up/down counter
// with programmable wrap value, load, clear and run/pause control.
module tick_bcd_counter
  import tick_cnt_pkg::*;
#(
  parameter int unsigned MAX_TENS = 5,
  parameter int unsigned MAX_ONES = 9
) (
  input  logic                clk_in,
  input  logic                reset,
  tick_bcd_counter_if.slave   bus
);

  localparam logic [BCD_W-1:0] MAX_T = BCD_W'(MAX_TENS);
  localparam logic [BCD_W-1:0] MAX_O = BCD_W'(MAX_ONES);
  localparam logic [7:0]       WRAP  = {MAX_T, MAX_O};

  state_t           state, state_nxt;
  logic             tick_d;
  logic             tick;
  logic             load_ok;
  logic             digit_load;
  logic             count_en;
  logic [BCD_W-1:0] ones_max;
  logic [BCD_W-1:0] ones, tens;
  logic             ones_co, tens_co;
  logic             tc_q, load_err_q;

  assign tick = bus.tick_src & ~tick_d;

  always_comb begin
    state_nxt = state;
    if (bus.clr) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  state_nxt = bus.run ? ST_RUN : ST_IDLE;
        ST_RUN:   state_nxt = bus.run ? ST_RUN : ST_PAUSE;
        ST_PAUSE: state_nxt = bus.run ? ST_RUN : ST_PAUSE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Both nibbles valid BCD makes a plain 8-bit compare equal to a decimal compare.
  always_comb begin
    load_ok    = (bus.load_val[7:4] <= BCD_NINE) && (bus.load_val[3:0] <= BCD_NINE)
                 && (bus.load_val <= WRAP);
    digit_load = bus.load && load_ok && !bus.clr;
    count_en   = tick && (state == ST_RUN) && bus.run && !bus.clr && !bus.load;
  end

  // Ones rolls at MAX_ONES only when the tens digit is about to wrap as well.
  always_comb begin
    ones_max = BCD_NINE;
    if (bus.up ? (tens == MAX_T) : (tens == '0)) begin
      ones_max = MAX_O;
    end
  end

  bcd_digit u_ones (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (count_en),
    .up       (bus.up),
    .clr      (bus.clr),
    .load     (digit_load),
    .max      (ones_max),
    .load_val (bus.load_val[3:0]),
    .co       (ones_co),
    .digit    (ones)
  );

  bcd_digit u_tens (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (ones_co),
    .up       (bus.up),
    .clr      (bus.clr),
    .load     (digit_load),
    .max      (MAX_T),
    .load_val (bus.load_val[7:4]),
    .co       (tens_co),
    .digit    (tens)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      tick_d     <= 1'b1;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_d     <= bus.tick_src;
      tc_q       <= tens_co;
      load_err_q <= bus.load && !bus.clr && !load_ok;
    end
  end

  assign bus.bcd_out  = {tens, ones};
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;
  assign bus.state_o  = state;

endmodule
